divider_sequencer: RTL and testbench

- Multi-cycle unsigned restoring divider controller for the CPU datapath (DIV instruction).
- Instantiates and sequences a single 32-bit adder_subtractor, driving it in subtract mode every iteration.
- Holds quotient/remainder for writeback to the LO/HI registers.
- start/busy/done handshake toward the control unit; one division in flight at a time.

---
 rtl/divider_sequencer.sv | 175 +++++++++++++++++
 tb/tb_divider_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - restoring divider controller sequencing one adder_subtractor; optional signed mode via DIVIDER_SIGNED_EN

// Ripple-style adder/subtractor; with sub=1 computes a - b and c_out=1 means no borrow.
module adder_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH-1:0] b_eff;

  // Invert b and inject a carry-in of 1 to form two's-complement subtraction.
  always_comb begin
    b_eff        = sub ? ~b : b;
    {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  end

endmodule

module divider_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {IDLE, ITER, DONE, SIGNFIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] part_quo;
  logic [WIDTH-1:0] div_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] diff;
  logic             rem_msb;
  logic             no_borrow;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  adder_subtractor #(.WIDTH(WIDTH)) u_addsub (
    .a     (rem_shift),
    .b     (div_reg),
    .sub   (1'b1),
    .sum   (diff),
    .c_out (no_borrow)
  );

  // One restoring step: shift {R,Q} left, trial-subtract the divisor, keep or restore.
  always_comb begin
    rem_shift = {part_rem[WIDTH-2:0], part_quo[WIDTH-1]};
    rem_msb   = part_rem[WIDTH-1];
    take      = rem_msb | no_borrow;
    rem_next  = take ? diff : rem_shift;
    quo_next  = {part_quo[WIDTH-2:0], take};
  end

  // Operand magnitudes fed to the iteration; most-negative value stays as its unsigned pattern.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dsr_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    dvd_mag = dividend;
    dsr_mag = divisor;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      part_rem  <= '0;
      part_quo  <= '0;
      div_reg   <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            part_rem <= '0;
            part_quo <= dvd_mag;
            div_reg  <= dsr_mag;
            cnt      <= '0;
`ifdef DIVIDER_SIGNED_EN
            neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r    <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              // Divide by zero completes immediately with the conventional all-ones quotient.
              state     <= DONE;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state    <= ITER;
              busy     <= 1'b1;
              div_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          part_rem <= rem_next;
          part_quo <= quo_next;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
`ifdef DIVIDER_SIGNED_EN
            state <= SIGNFIX;
`else
            state     <= DONE;
            quotient  <= quo_next;
            remainder <= rem_next;
            busy      <= 1'b0;
            done      <= 1'b1;
`endif
          end
        end
`ifdef DIVIDER_SIGNED_EN
        SIGNFIX: begin
          // Quotient sign follows the operand sign mismatch; remainder follows the dividend.
          state     <= DONE;
          quotient  <= neg_q ? -part_quo : part_quo;
          remainder <= neg_r ? -part_rem : part_rem;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// tb/tb_divider_sequencer.sv - directed plus randomized bench for divider_sequencer against an arithmetic reference
module tb_divider_sequencer;

`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  int vectors = 0;
  int miscompares = 0;

  divider_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference division from plain arithmetic on magnitudes.
  task automatic ref_div(input logic [31:0] n, input logic [31:0] d,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic [31:0] mn, md, uq, ur;
    if (d == 0) begin
      q = 32'hFFFFFFFF; r = n; dz = 1'b1;
    end else begin
      dz = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      mn = n[31] ? (32'd0 - n) : n;
      md = d[31] ? (32'd0 - d) : d;
      uq = mn / md;
      ur = mn % md;
      q = (n[31] != d[31]) ? (32'd0 - uq) : uq;
      r = n[31] ? (32'd0 - ur) : ur;
`else
      mn = n; md = d;
      uq = mn / md;
      ur = mn % md;
      q = uq; r = ur;
`endif
    end
  endtask

  task automatic start_op(input logic [31:0] n, input logic [31:0] d);
    @(negedge clk);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the cycle after accept; counts cycles until done, bounded.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_check(input string tag, input logic [31:0] n, input logic [31:0] d);
    int lat, bc;
    logic [31:0] eq, er;
    logic edz;
    ref_div(n, d, eq, er, edz);
    start_op(n, d);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, (d == 0) ? 32'd0 : LAT);
    check({tag, "_busy"}, bc, (d == 0) ? 32'd0 : LAT);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, quotient, eq);
  endtask

  initial begin
    int lat, bc, ones;
    logic [31:0] n, d;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_ctl", {29'd0, busy, done, div_zero}, 32'd0);
    rst = 1'b0;

    run_check("d100_7", 32'd100, 32'd7);
    check("d100_7_qc", quotient, 32'd14);
    check("d100_7_rc", remainder, 32'd2);

    run_check("max_1", 32'hFFFFFFFF, 32'd1);
    run_check("max_msb", 32'hFFFFFFFF, 32'h80000000);
`ifndef DIVIDER_SIGNED_EN
    check("max_msb_qc", quotient, 32'd1);
    check("max_msb_rc", remainder, 32'h7FFFFFFF);
`endif

    run_check("dz", 32'd1234, 32'd0);
    check("dz_qc", quotient, 32'hFFFFFFFF);
    check("dz_rc", remainder, 32'd1234);
    run_check("after_dz", 32'd9, 32'd3);
    check("after_dz_qc", quotient, 32'd3);

    // Start pulse mid-iteration must be ignored; then back-to-back from DONE.
    start_op(32'd50, 32'd5);
    repeat (9) @(negedge clk);
    dividend = 32'd8; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("ign_lat", lat + 10, LAT);
    check("ign_q", quotient, 32'd10);
    check("ign_r", remainder, 32'd0);
    dividend = 32'd8; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("b2b_lat", lat, LAT);
    check("b2b_q", quotient, 32'd4);
    check("b2b_r", remainder, 32'd0);

    // Reset mid-operation aborts with no done pulse.
    start_op(32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd7; divisor = 32'd0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    check("abort_ctl", {29'd0, busy, done, div_zero}, 32'd0);
    ones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ones++;
    end
    check("abort_nodone", ones, 32'd0);
    run_check("after_abort", 32'd1000, 32'd3);
    check("after_abort_qc", quotient, 32'd333);
    check("after_abort_rc", remainder, 32'd1);

`ifdef DIVIDER_SIGNED_EN
    run_check("s_neg_n", 32'hFFFFFF9C, 32'd7);
    check("s_neg_n_qc", quotient, 32'hFFFFFFF2);
    check("s_neg_n_rc", remainder, 32'hFFFFFFFE);
    run_check("s_neg_d", 32'd100, 32'hFFFFFFF9);
    check("s_neg_d_qc", quotient, 32'hFFFFFFF2);
    check("s_neg_d_rc", remainder, 32'd2);
    run_check("s_min", 32'h80000000, 32'hFFFFFFFF);
`endif

    for (int i = 0; i < 400; i++) begin
      n = $urandom;
      d = $urandom;
      case ($urandom_range(0, 7))
        0: d = 32'd0;
        1: d = $urandom_range(1, 15);
        2: n = $urandom_range(0, 100);
        3: d = d >> $urandom_range(0, 31);
        default: ;
      endcase
      run_check("rand", n, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
